gfx_clip_receiver: RTL and testbench
====================================

# gfx_clip_receiver

Receiving end of the rasterizer pixel-write handshake. It accepts one pixel per `write_i`/`ack_o` handshake, clips it against the clip rectangle and the target bounds, and queues surviving pixels in a small FIFO. The FIFO drives the fragment stage through a `pixel_write_o`/`pixel_ack_i` handshake. The block sits between the rasterizer and the fragment processor.

## Interface
Parameters:
- `point_width`, 16, coordinate width.
- `fifo_depth_log2`, 2, log2 of the FIFO depth (default 4 entries).

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous and active-high.
- `clipping_enable_i`  in  1  enables the clip-rectangle test.
- `clip_pixel0_x_i`, `clip_pixel0_y_i`  in  point_width  inclusive clip top-left.
- `clip_pixel1_x_i`, `clip_pixel1_y_i`  in  point_width  exclusive clip bottom-right.
- `target_size_x_i`, `target_size_y_i`  in  point_width  target dimensions, exclusive.
- `write_i`  in  1  pixel request from the rasterizer; level signal.
- `x_counter_i`, `y_counter_i`, `u_i`, `v_i`  in  point_width each  pixel and texture coordinates.
- `ack_o`  out  1  single-cycle accept pulse back to the rasterizer.
- `pixel_write_o`  out  1  FIFO non-empty; head entry valid.
- `x_o`, `y_o`, `u_o`, `v_o`  out  point_width each  FIFO head entry.
- `pixel_ack_i`  in  1  downstream pops the head entry.
- `busy_o`  out  1  FIFO non-empty or `ack_o` high.

## Operation
- All coordinates are unsigned.
- A pixel is in-bounds when `x < target_size_x_i` and `y < target_size_y_i`.
- When `clipping_enable_i` is high, in-bounds additionally requires `clip_pixel0_x_i <= x < clip_pixel1_x_i` and `clip_pixel0_y_i <= y < clip_pixel1_y_i`.
- Accept FSM states:
  - **S_IDLE**: at a clock edge with `write_i` = 1:
    - Out-of-bounds pixel: ack it and discard it; move to S_ACK.
    - In-bounds pixel with space available: push `{x,y,u,v}` into the FIFO; move to S_ACK.
    - In-bounds pixel with the FIFO full and no pop this cycle: stall in S_IDLE with `ack_o` = 0.
  - **S_ACK**: `ack_o` = 1 for exactly one cycle. `write_i` is ignored, because it still carries the already-consumed coordinate. Always return to S_IDLE.
- "Space available" means count < depth, or count == depth with `pixel_ack_i` = 1 in the same cycle (push and pop together).
- FIFO:
  - Circular buffer; read and write pointers are `fifo_depth_log2` bits and wrap modulo depth.
  - The count is `fifo_depth_log2+1` bits wide.
  - Outputs `x_o`/`y_o`/`u_o`/`v_o` show the head entry combinationally.
  - `pixel_ack_i` with the FIFO empty is ignored: no pointer movement, no underflow.
  - Simultaneous push and pop leaves the count unchanged.
- `clipping_enable_i` and the clip/target inputs are sampled at the accept edge only. Changing them afterwards does not affect pixels already queued.

## Timing
- Reset values: `ack_o` = 0, `pixel_write_o` = 0, `busy_o` = 0, `x_o`/`y_o`/`u_o`/`v_o` = 0, FSM in S_IDLE, pointers and count = 0.
- Reset asserted mid-operation flushes the FIFO and drops any pending ack immediately.
- Accept edge E → `ack_o` high during cycle E..E+1.
- Earliest next accept is edge E+2. Peak throughput is one pixel per 2 cycles.
- A push at edge E → `pixel_write_o` high after E, with 1-cycle latency into an empty FIFO.
- Pop: `pixel_ack_i` sampled high at edge P → the next entry (or `pixel_write_o` = 0) appears after P.
- A discarded pixel never asserts `pixel_write_o`.

## Configuration
- `GFX_CLIP_STATS_EN`:
  - Defined: adds outputs `accepted_count_o` and `discarded_count_o` (32 bits each, saturating at 0xFFFFFFFF, reset to 0).
    - `accepted_count_o` increments on each push.
    - `discarded_count_o` increments on each clipped-out ack.
  - Undefined: neither port nor counter exists; the rest of the behaviour is identical.

## Test plan
- Single pixel, clip off, target 640×480: `write_i` held with (10,20) until `ack_o` → `ack_o` 1 cycle later; `pixel_write_o` with x=10, y=20; `pixel_ack_i` → FIFO empty.
- Clip enabled, clip (5,5)-(10,10): pixels x=4, 5, 9, 10 at y=7 → only x=5 and x=9 reach the FIFO; all four are acked; `discarded_count_o` = 2 with stats enabled.
- Target bounds: pixel (640,0) with target 640×480 and clip off → acked, discarded, `pixel_write_o` stays 0.
- Full FIFO, depth 4, `pixel_ack_i` = 0: five in-bounds writes → four acks, fifth stalls with `ack_o` = 0. Pulse `pixel_ack_i` → fifth is pushed and acked in that cycle's edge sequence; order of `x_o` preserved across the pointer wrap.
- Rect stream 3×2 driven back-to-back, coordinates advancing one cycle after each `ack_o` → exactly 6 pushes with no duplicate coordinate; the `write_i` cycle during S_ACK is never re-accepted.
- Reset pulse asserted asynchronously with 3 entries queued and `ack_o` high → all outputs 0 immediately; after release, the first write is handled normally.

Source files
------------

// File: rtl/gfx_clip_receiver.sv
// Rasterizer pixel receiver: clips against clip rect/target bounds, queues survivors in a FIFO; GFX_CLIP_STATS_EN adds counters.
// Latency: ack_o one cycle after the accept edge; pixel_write_o one cycle after a push into an empty FIFO.
// Backpressure: an in-bounds pixel stalls (no ack) while the FIFO is full and not popped that cycle.
module gfx_clip_receiver #(
    parameter int point_width     = 16,
    parameter int fifo_depth_log2 = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clipping_enable_i,
    input  logic [point_width-1:0] clip_pixel0_x_i,
    input  logic [point_width-1:0] clip_pixel0_y_i,
    input  logic [point_width-1:0] clip_pixel1_x_i,
    input  logic [point_width-1:0] clip_pixel1_y_i,
    input  logic [point_width-1:0] target_size_x_i,
    input  logic [point_width-1:0] target_size_y_i,
    input  logic                   write_i,
    input  logic [point_width-1:0] x_counter_i,
    input  logic [point_width-1:0] y_counter_i,
    input  logic [point_width-1:0] u_i,
    input  logic [point_width-1:0] v_i,
    output logic                   ack_o,
    output logic                   pixel_write_o,
    output logic [point_width-1:0] x_o,
    output logic [point_width-1:0] y_o,
    output logic [point_width-1:0] u_o,
    output logic [point_width-1:0] v_o,
    input  logic                   pixel_ack_i,
    output logic                   busy_o
`ifdef GFX_CLIP_STATS_EN
    ,
    output logic [31:0]            accepted_count_o,
    output logic [31:0]            discarded_count_o
`endif
);

    localparam int depth = 1 << fifo_depth_log2;
    localparam logic [fifo_depth_log2:0] depth_cnt = {1'b1, {fifo_depth_log2{1'b0}}};

    typedef struct packed {
        logic [point_width-1:0] x;
        logic [point_width-1:0] y;
        logic [point_width-1:0] u;
        logic [point_width-1:0] v;
    } pix_t;

    typedef enum logic {
        S_IDLE,
        S_ACK
    } state_t;

    state_t                       state_q, state_d;
    pix_t                         mem_q [depth];
    pix_t                         mem_d [depth];
    logic [fifo_depth_log2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [fifo_depth_log2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [fifo_depth_log2:0]     count_q, count_d;

    logic fifo_empty;
    logic fifo_full;
    logic space_avail;
    logic target_ok;
    logic clip_ok;
    logic in_bounds;
    logic push;
    logic pop;
    pix_t head;

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == depth_cnt);
    assign pop         = pixel_ack_i && !fifo_empty;
    // A full FIFO still has room when the head leaves on the same edge.
    assign space_avail = !fifo_full || pixel_ack_i;

    assign target_ok = (x_counter_i < target_size_x_i) && (y_counter_i < target_size_y_i);
    assign clip_ok   = (x_counter_i >= clip_pixel0_x_i) && (x_counter_i < clip_pixel1_x_i) &&
                       (y_counter_i >= clip_pixel0_y_i) && (y_counter_i < clip_pixel1_y_i);
    assign in_bounds = target_ok && (!clipping_enable_i || clip_ok);

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (write_i) begin
                    if (!in_bounds) begin
                        state_d = S_ACK;
                    end else if (space_avail) begin
                        push    = 1'b1;
                        state_d = S_ACK;
                    end
                end
            end
            // write_i still holds the pixel just consumed, so it is ignored here.
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{x: x_counter_i, y: y_counter_i, u: u_i, v: v_i};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    // Head is masked when empty so stale entries never leak onto the outputs.
    assign head          = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign x_o           = head.x;
    assign y_o           = head.y;
    assign u_o           = head.u;
    assign v_o           = head.v;
    assign ack_o         = (state_q == S_ACK);
    assign pixel_write_o = !fifo_empty;
    assign busy_o        = !fifo_empty || ack_o;

`ifdef GFX_CLIP_STATS_EN
    logic [31:0] accepted_count_q, accepted_count_d;
    logic [31:0] discarded_count_q, discarded_count_d;
    logic        discard;

    assign discard = (state_q == S_IDLE) && write_i && !in_bounds;

    always_comb begin
        accepted_count_d  = accepted_count_q;
        discarded_count_d = discarded_count_q;
        if (push && (accepted_count_q != 32'hFFFF_FFFF)) begin
            accepted_count_d = accepted_count_q + 32'd1;
        end
        if (discard && (discarded_count_q != 32'hFFFF_FFFF)) begin
            discarded_count_d = discarded_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            accepted_count_q  <= '0;
            discarded_count_q <= '0;
        end else begin
            accepted_count_q  <= accepted_count_d;
            discarded_count_q <= discarded_count_d;
        end
    end

    assign accepted_count_o  = accepted_count_q;
    assign discarded_count_o = discarded_count_q;
`endif

endmodule

// File: tb/tb_gfx_clip_receiver.sv
// Directed bench for gfx_clip_receiver: queue-based reference model checked every cycle, plus literal expectations.
module tb_gfx_clip_receiver;

    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clip_en = 1'b0;
    logic [PW-1:0] c0x = '0, c0y = '0, c1x = '0, c1y = '0;
    logic [PW-1:0] tx = '0, ty = '0;
    logic          write_i = 1'b0;
    logic [PW-1:0] xi = '0, yi = '0, ui = '0, vi = '0;
    logic          pixel_ack_i = 1'b0;
    logic          ack_o, pixel_write_o, busy_o;
    logic [PW-1:0] x_o, y_o, u_o, v_o;
`ifdef GFX_CLIP_STATS_EN
    logic [31:0]   acc_cnt, disc_cnt;
`endif

    always #5 clk = ~clk;

    gfx_clip_receiver #(.point_width(PW), .fifo_depth_log2(2)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .clipping_enable_i (clip_en),
        .clip_pixel0_x_i   (c0x),
        .clip_pixel0_y_i   (c0y),
        .clip_pixel1_x_i   (c1x),
        .clip_pixel1_y_i   (c1y),
        .target_size_x_i   (tx),
        .target_size_y_i   (ty),
        .write_i           (write_i),
        .x_counter_i       (xi),
        .y_counter_i       (yi),
        .u_i               (ui),
        .v_i               (vi),
        .ack_o             (ack_o),
        .pixel_write_o     (pixel_write_o),
        .x_o               (x_o),
        .y_o               (y_o),
        .u_o               (u_o),
        .v_o               (v_o),
        .pixel_ack_i       (pixel_ack_i),
        .busy_o            (busy_o)
`ifdef GFX_CLIP_STATS_EN
        ,
        .accepted_count_o  (acc_cnt),
        .discarded_count_o (disc_cnt)
`endif
    );

    int nvec = 0;
    int nmis = 0;
    int last_lat = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of pixels and a pending-ack flag, updated from the accept rules.
    logic [63:0] mq[$];
    bit          m_ack = 1'b0;
    bit          m_nack, m_push, m_inb;
    int          m_n;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_ack = 1'b0;
        end else begin
            m_n    = mq.size();
            m_push = 1'b0;
            m_nack = 1'b0;
            if (!m_ack && write_i) begin
                m_inb = (xi < tx) && (yi < ty) &&
                        (!clip_en || (xi >= c0x && xi < c1x && yi >= c0y && yi < c1y));
                if (!m_inb) begin
                    m_nack = 1'b1;
                end else if (m_n < 4 || pixel_ack_i) begin
                    m_push = 1'b1;
                    m_nack = 1'b1;
                end
            end
            if (pixel_ack_i && m_n > 0) void'(mq.pop_front());
            if (m_push) mq.push_back({xi, yi, ui, vi});
            m_ack = m_nack;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("ack_o", ack_o, m_ack);
            chk("pixel_write_o", pixel_write_o, mq.size() != 0);
            chk("busy_o", busy_o, (mq.size() != 0) || m_ack);
            if (mq.size() != 0) chk("head", {x_o, y_o, u_o, v_o}, mq[0]);
        end
    end

    // Records entries actually handed downstream.
    logic [31:0] pops[$];
    bit          mon_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en && pixel_write_o && pixel_ack_i) pops.push_back({x_o, y_o});
    end

    task automatic cfg(input logic en, input logic [PW-1:0] ax, ay, bx, by, sx, sy);
        clip_en = en; c0x = ax; c0y = ay; c1x = bx; c1y = by; tx = sx; ty = sy;
    endtask

    task automatic send(input logic [PW-1:0] px, py, pu, pv, input bit hold);
        int n;
        write_i = 1'b1; xi = px; yi = py; ui = pu; vi = pv;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack_o && n < 40);
        last_lat = n;
        chk("ack_seen", ack_o, 1'b1);
        @(posedge clk); #1;
        if (!hold) write_i = 1'b0;
    endtask

    task automatic pop1();
        pixel_ack_i = 1'b1;
        @(posedge clk); #1;
        pixel_ack_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", ack_o, 1'b0);
        chk("rst_pw", pixel_write_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_head", {x_o, y_o, u_o, v_o}, 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single pixel, clip off
        cfg(1'b0, 0, 0, 0, 0, 640, 480);
        send(10, 20, 3, 4, 1'b0);
        chk("t1_lat", last_lat, 2);
        chk("t1_pw", pixel_write_o, 1'b1);
        chk("t1_x", x_o, 10);
        chk("t1_y", y_o, 20);
        pop1();
        chk("t1_empty", pixel_write_o, 1'b0);
        chk("t1_busy", busy_o, 1'b0);

        // Clip rect (5,5)-(10,10), x = 4,5,9,10 at y = 7
        cfg(1'b1, 5, 5, 10, 10, 640, 480);
        send(4, 7, 1, 1, 1'b1);
        chk("t2_lat_a", last_lat, 2);
        send(5, 7, 2, 2, 1'b1);
        chk("t2_lat_b", last_lat, 2);
        send(9, 7, 3, 3, 1'b1);
        send(10, 7, 4, 4, 1'b0);
        chk("t2_x0", x_o, 5);
        pop1();
        chk("t2_x1", x_o, 9);
        pop1();
        chk("t2_empty", pixel_write_o, 1'b0);
`ifdef GFX_CLIP_STATS_EN
        chk("t2_disc", disc_cnt, 2);
        chk("t2_acc", acc_cnt, 3);
`endif

        // Target bounds, clip off
        cfg(1'b0, 0, 0, 0, 0, 640, 480);
        send(640, 0, 0, 0, 1'b0);
        chk("t3_discard_pw", pixel_write_o, 1'b0);
        send(0, 480, 0, 0, 1'b0);
        chk("t3_discard_pw2", pixel_write_o, 1'b0);
        send(639, 479, 5, 6, 1'b0);
        chk("t3_edge_x", x_o, 639);
        chk("t3_edge_y", y_o, 479);
        pop1();
`ifdef GFX_CLIP_STATS_EN
        chk("t3_disc", disc_cnt, 4);
`endif

        // Full FIFO: fifth write stalls until a pop
        for (int i = 0; i < 4; i++) send(16'(100 + i), 1, 0, 0, 1'b0);
        write_i = 1'b1; xi = 104; yi = 1; ui = 0; vi = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_stall", ack_o, 1'b0);
        end
        @(posedge clk); #1;
        pixel_ack_i = 1'b1;
        @(posedge clk); #1;
        pixel_ack_i = 1'b0;
        chk("t4_ack", ack_o, 1'b1);
        chk("t4_head", x_o, 101);
        @(posedge clk); #1;
        write_i = 1'b0;
        for (int i = 101; i <= 104; i++) begin
            chk("t4_order", x_o, i);
            pop1();
        end
        chk("t4_empty", pixel_write_o, 1'b0);

        // 3x2 rect streamed back to back with downstream always ready
        pixel_ack_i = 1'b1;
        mon_en = 1'b1;
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 3; x++)
                send(16'(x), 16'(y), 16'(x + 50), 16'(y + 60), !(x == 2 && y == 1));
        repeat (3) @(posedge clk);
        #1;
        pixel_ack_i = 1'b0;
        mon_en = 1'b0;
        chk("t5_count", pops.size(), 6);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] e;
            e = {16'(i % 3), 16'(i / 3)};
            if (i < pops.size()) chk("t5_seq", pops[i], e);
        end

        // Asynchronous reset with 3 queued and ack high
        send(1, 1, 1, 1, 1'b0);
        send(2, 2, 2, 2, 1'b0);
        write_i = 1'b1; xi = 3; yi = 3; ui = 3; vi = 3;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack_o && n < 40);
        chk("t6_ack_before", ack_o, 1'b1);
        chk("t6_pw_before", pixel_write_o, 1'b1);
        #1;
        rst = 1'b1;
        write_i = 1'b0;
        #1;
        chk("t6_ack", ack_o, 1'b0);
        chk("t6_pw", pixel_write_o, 1'b0);
        chk("t6_busy", busy_o, 1'b0);
        chk("t6_head", {x_o, y_o, u_o, v_o}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(7, 8, 9, 10, 1'b0);
        chk("t6_lat", last_lat, 2);
        chk("t6_entry", {x_o, y_o, u_o, v_o}, {16'd7, 16'd8, 16'd9, 16'd10});
`ifdef GFX_CLIP_STATS_EN
        chk("t6_acc", acc_cnt, 1);
        chk("t6_disc", disc_cnt, 0);
`endif
        pop1();
        chk("t6_empty", pixel_write_o, 1'b0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
